ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the datapath load/store path; port 1 is a secondary master such as an I/O capture or display-refresh engine.
- Port 0 wins by default. A wait counter guarantees port 1 a slot after MAX_WAIT consecutive denied cycles.
- Sits between the datapath/secondary master and the RAM address, write-enable and data pins. The RAM has a 1-cycle synchronous read.

Parameters:
- AW, 10, address width (matches the RAM address bus).
- DW, 32, data width.
- MAX_WAIT, 4, denied cycles for port 1 before it pre-empts port 0. Legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_req  in  1  port 0 access request.
- r0_we  in  1  port 0 write (1) / read (0).
- r0_addr  in  AW  port 0 address.
- r0_wdata  in  DW  port 0 write data.
- r0_gnt  out  1  port 0 granted this cycle (combinational).
- r0_rvalid  out  1  port 0 read data valid.
- r0_rdata  out  DW  port 0 read data.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as port 0, for port 1.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid 1 cycle after a read address is presented.

Behaviour:
- Reset (async, rst_n=0):
  - wait_cnt=0; rd_pend=0; rd_owner=0.
  - r0_rvalid=0, r1_rvalid=0; r0_rdata=0, r1_rdata=0.
  - Grants forced 0; mem_we forced 0; mem_addr=0; mem_wdata=0.
  - Reset mid-transaction drops any pending read; no rvalid is issued after release.
- Arbitration (combinational, every cycle):
  - starve = r1_req && (wait_cnt >= MAX_WAIT).
  - r1_gnt = r1_req && (!r0_req || starve).
  - r0_gnt = r0_req && !r1_gnt.
  - At most one grant per cycle.
- Memory drive:
  - mem_addr/mem_we/mem_wdata come from the granted port.
  - With no grant: mem_we=0, and mem_addr/mem_wdata hold the port 0 values (don't-care).
  - A write commits at the clock edge ending the grant cycle.
- Read return (1-cycle latency):
  - On a granted read, register rd_pend=1 and rd_owner=granted port.
  - Next cycle, rX_rvalid=1 for rd_owner only, and rX_rdata=mem_rdata (passthrough).
  - rX_rdata of the other port holds its last value.
  - Writes never produce rvalid.
  - Back-to-back reads from either port are sustained at 1 per cycle.
- Requester protocol:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - A requester may deassert req in the cycle after gnt or keep it high to issue another access.
  - Dropping req without a grant is legal; the request is abandoned.
- Starvation counter (registered):
  - r1_req && !r1_gnt: wait_cnt++, saturating at 255.
  - r1_gnt, or !r1_req: wait_cnt=0.
  - Therefore port 1 is granted no later than the (MAX_WAIT+1)th cycle of continuous request.
  - After a starve grant, port 0 wins again the next cycle if requesting.
- Simultaneous requests:
  - Both req with wait_cnt<MAX_WAIT: port 0 wins.
  - Both req with wait_cnt>=MAX_WAIT: port 1 wins and port 0 stalls one cycle.
- Read-after-write, same address, consecutive cycles: the read returns the newly written data (RAM write-first ordering is guaranteed by the grant sequence).
- No combinational path from mem_rdata to any grant.

Test Plan:
- Reset held, all req=1 -> gnt=0, mem_we=0, rvalid=0. Release -> r0_gnt=1 in the first cycle.
- Only r1 reads addr 0x005 where RAM[5]=0xDEADBEEF -> r1_gnt same cycle, r1_rvalid=1 with r1_rdata=0xDEADBEEF next cycle, r0_rvalid=0.
- r0 and r1 both request continuously, MAX_WAIT=4 -> r0 granted cycles 0-3, r1 at cycle 4, r0 cycles 5-8, r1 at cycle 9. Repeating pattern 4:1.
- r0 writes 0x12345678 to 0x3FF, then r1 reads 0x3FF the next cycle -> r1_rdata=0x12345678 one cycle after r1_gnt. Address 0x3FF exercises the top of the address range.
- Alternating r0 read 0x001 / r1 read 0x002 on consecutive grants -> each rvalid pulses only for its owner, with the correct data, 1 cycle after its grant.
- rst_n pulsed low during a granted read -> no rvalid after release; wait_cnt=0 (r1 needs MAX_WAIT denied cycles again before pre-empting).

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the single-port data RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_port_arbiter_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for a single-port RAM with 1-cycle synchronous read.
// Port 0 has priority; port 1 pre-empts after MAX_WAIT consecutive denied cycles.
module ram_port_arbiter #(
    parameter int unsigned AW       = 10,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic               clock,
    input logic               rst_n,
    ram_port_arbiter_if.slave bus
);
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    logic [7:0]    r_wait_cnt;
    logic          r_rd_pend;
    logic          r_rd_owner;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_starve;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_rd_gnt;
    logic          w_rvalid0;
    logic          w_rvalid1;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        w_starve = bus.r1_req && (r_wait_cnt >= WAIT_LIM);
        w_gnt1   = rst_n && bus.r1_req && (!bus.r0_req || w_starve);
        w_gnt0   = rst_n && bus.r0_req && !w_gnt1;
        w_rd_gnt = (w_gnt0 && !bus.r0_we) || (w_gnt1 && !bus.r1_we);
    end

    always_comb begin
        w_addr        = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
        w_wdata       = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;
        bus.mem_addr  = rst_n ? w_addr  : '0;
        bus.mem_wdata = rst_n ? w_wdata : '0;
        bus.mem_we    = (w_gnt0 && bus.r0_we) || (w_gnt1 && bus.r1_we);
        bus.r0_gnt    = w_gnt0;
        bus.r1_gnt    = w_gnt1;
    end

    always_comb begin
        w_rvalid0     = r_rd_pend && !r_rd_owner;
        w_rvalid1     = r_rd_pend && r_rd_owner;
        bus.r0_rvalid = w_rvalid0;
        bus.r1_rvalid = w_rvalid1;
        bus.r0_rdata  = w_rvalid0 ? bus.mem_rdata : r_rdata0;
        bus.r1_rdata  = w_rvalid1 ? bus.mem_rdata : r_rdata1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_rd_pend <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_owner <= w_gnt1;
            end
            if (bus.r1_req && !w_gnt1) begin
                if (r_wait_cnt != 8'hFF) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            // Read data is a passthrough while valid; capture it so it holds afterwards.
            if (w_rvalid0) begin
                r_rdata0 <= bus.mem_rdata;
            end
            if (w_rvalid1) begin
                r_rdata1 <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_ram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clock;
    logic rst_n;
    int   checks;
    int   errors;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Physical RAM driven by the DUT's memory pins.
    logic [DW-1:0] ram [1024];
    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: shadow memory, one pending read slot, denied-cycle count.
    logic [DW-1:0] m_mem [1024];
    int            m_wait;
    bit            m_pend;
    bit            m_owner;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] m_hold0;
    logic [DW-1:0] m_hold1;

    initial begin
        m_wait = 0; m_pend = 0; m_owner = 0; m_pdata = '0; m_hold0 = '0; m_hold1 = '0;
    end

    always @(negedge clock) begin
        bit g0, g1, v0, v1;
        if (!rst_n) begin
            chk("m_rst_gnt0", bus.r0_gnt, 1'b0);
            chk("m_rst_gnt1", bus.r1_gnt, 1'b0);
            chk("m_rst_we", bus.mem_we, 1'b0);
            chk("m_rst_addr", bus.mem_addr, '0);
            chk("m_rst_wdata", bus.mem_wdata, '0);
            chk("m_rst_rv0", bus.r0_rvalid, 1'b0);
            chk("m_rst_rv1", bus.r1_rvalid, 1'b0);
            chk("m_rst_rd0", bus.r0_rdata, '0);
            chk("m_rst_rd1", bus.r1_rdata, '0);
            m_wait = 0; m_pend = 0; m_owner = 0; m_hold0 = '0; m_hold1 = '0;
        end else begin
            g1 = bus.r1_req && (!bus.r0_req || m_wait >= MW);
            g0 = bus.r0_req && !g1;
            v0 = m_pend && !m_owner;
            v1 = m_pend && m_owner;
            chk("m_gnt0", bus.r0_gnt, g0);
            chk("m_gnt1", bus.r1_gnt, g1);
            chk("m_we", bus.mem_we, (g0 && bus.r0_we) || (g1 && bus.r1_we));
            chk("m_addr", bus.mem_addr, g1 ? bus.r1_addr : bus.r0_addr);
            chk("m_wdata", bus.mem_wdata, g1 ? bus.r1_wdata : bus.r0_wdata);
            chk("m_rv0", bus.r0_rvalid, v0);
            chk("m_rv1", bus.r1_rvalid, v1);
            chk("m_rd0", bus.r0_rdata, v0 ? m_pdata : m_hold0);
            chk("m_rd1", bus.r1_rdata, v1 ? m_pdata : m_hold1);
            if (v0) m_hold0 = m_pdata;
            if (v1) m_hold1 = m_pdata;
            m_pend = 0;
            if (g0) begin
                if (bus.r0_we) m_mem[bus.r0_addr] = bus.r0_wdata;
                else begin m_pend = 1; m_owner = 0; m_pdata = m_mem[bus.r0_addr]; end
            end
            if (g1) begin
                if (bus.r1_we) m_mem[bus.r1_addr] = bus.r1_wdata;
                else begin m_pend = 1; m_owner = 1; m_pdata = m_mem[bus.r1_addr]; end
            end
            if (bus.r1_req && !g1) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
            else m_wait = 0;
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic set0(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    endtask

    task automatic set1(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]   = i * 32'h9E37_79B9;
            m_mem[i] = i * 32'h9E37_79B9;
        end
        ram[1] = 32'h1111_0001; m_mem[1] = 32'h1111_0001;
        ram[2] = 32'h2222_0002; m_mem[2] = 32'h2222_0002;
        ram[5] = 32'hDEAD_BEEF; m_mem[5] = 32'hDEAD_BEEF;

        // Reset held with both ports requesting.
        rst_n = 1'b0;
        set0(1, 0, 10'h000, 32'h0);
        set1(1, 0, 10'h000, 32'h0);
        nxt(); nxt();
        #1;
        chk("rst_gnt0", bus.r0_gnt, 1'b0);
        chk("rst_gnt1", bus.r1_gnt, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_rv0", bus.r0_rvalid, 1'b0);
        chk("rst_rv1", bus.r1_rvalid, 1'b0);
        nxt();
        rst_n = 1'b1;
        #1;
        chk("rel_gnt0", bus.r0_gnt, 1'b1);
        chk("rel_gnt1", bus.r1_gnt, 1'b0);

        // Port 1 alone reads address 5.
        nxt();
        set0(0, 0, 10'h000, 32'h0);
        set1(1, 0, 10'h005, 32'h0);
        #1;
        chk("r1_only_gnt", bus.r1_gnt, 1'b1);
        nxt();
        set1(0, 0, 10'h005, 32'h0);
        #1;
        chk("r1_only_rv", bus.r1_rvalid, 1'b1);
        chk("r1_only_rd", bus.r1_rdata, 32'hDEAD_BEEF);
        chk("r1_only_rv0", bus.r0_rvalid, 1'b0);

        // Continuous contention: 4:1 pattern.
        nxt();
        set0(1, 0, 10'h001, 32'h0);
        set1(1, 0, 10'h002, 32'h0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("cont_gnt1", bus.r1_gnt, (c % 5) == 4);
            chk("cont_gnt0", bus.r0_gnt, (c % 5) != 4);
            if (c == 5) chk("cont_rd1", bus.r1_rdata, 32'h2222_0002);
            nxt();
        end

        // Write top address from port 0, read it back from port 1.
        set1(0, 0, 10'h000, 32'h0);
        set0(1, 1, 10'h3FF, 32'h1234_5678);
        #1;
        chk("raw_wgnt", bus.r0_gnt, 1'b1);
        chk("raw_we", bus.mem_we, 1'b1);
        chk("raw_addr", bus.mem_addr, 10'h3FF);
        nxt();
        set0(0, 0, 10'h000, 32'h0);
        set1(1, 0, 10'h3FF, 32'h0);
        #1;
        chk("raw_rgnt", bus.r1_gnt, 1'b1);
        nxt();
        set1(0, 0, 10'h000, 32'h0);
        #1;
        chk("raw_rv", bus.r1_rvalid, 1'b1);
        chk("raw_rd", bus.r1_rdata, 32'h1234_5678);

        // Alternating owners.
        nxt();
        set0(1, 0, 10'h001, 32'h0);
        #1;
        chk("alt_g0", bus.r0_gnt, 1'b1);
        nxt();
        set0(0, 0, 10'h000, 32'h0);
        set1(1, 0, 10'h002, 32'h0);
        #1;
        chk("alt_g1", bus.r1_gnt, 1'b1);
        chk("alt_rv0a", bus.r0_rvalid, 1'b1);
        chk("alt_rd0a", bus.r0_rdata, 32'h1111_0001);
        chk("alt_rv1a", bus.r1_rvalid, 1'b0);
        nxt();
        set1(0, 0, 10'h000, 32'h0);
        set0(1, 0, 10'h001, 32'h0);
        #1;
        chk("alt_rv1b", bus.r1_rvalid, 1'b1);
        chk("alt_rd1b", bus.r1_rdata, 32'h2222_0002);
        chk("alt_rv0b", bus.r0_rvalid, 1'b0);
        chk("alt_hold0", bus.r0_rdata, 32'h1111_0001);
        nxt();
        set0(0, 0, 10'h000, 32'h0);
        #1;
        chk("alt_rv0c", bus.r0_rvalid, 1'b1);
        chk("alt_rv1c", bus.r1_rvalid, 1'b0);
        chk("alt_hold1", bus.r1_rdata, 32'h2222_0002);

        // Reset pulse while a read is outstanding.
        nxt();
        set1(1, 0, 10'h005, 32'h0);
        #1;
        chk("rp_gnt", bus.r1_gnt, 1'b1);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("rp_rv_in_rst", bus.r1_rvalid, 1'b0);
        nxt();
        rst_n = 1'b1;
        set0(1, 0, 10'h001, 32'h0);
        set1(1, 0, 10'h002, 32'h0);
        #1;
        chk("rp_rv_after", bus.r1_rvalid, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("rp_wait_gnt1", bus.r1_gnt, c == 4);
            nxt();
            #1;
        end

        // Randomized traffic, occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            nxt();
            rst_n = ($urandom_range(0, 149) != 0);
            set0($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 7)), $urandom);
            set1($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 9) == 0) ? 10'h3FF : 10'($urandom_range(0, 7)), $urandom);
        end
        nxt();
        rst_n = 1'b1;
        set0(0, 0, 10'h000, 32'h0);
        set1(0, 0, 10'h000, 32'h0);
        nxt(); nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
